fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction fetch stage sitting directly downstream of the program counter: it presents `prog_ctr` to the synchronous instruction ROM, captures the returned instruction, and queues it with its PC in a small FIFO for the decode stage. It applies backpressure to the PC through `pc_hold`, discards wrong-path instructions when decode reports a taken absolute jump, and stops fetching after a HALT opcode.

## Interface
- `D`, 10, PC / instruction-address width.
- `W`, 9, instruction width.
- `DEPTH`, 2, FIFO entries (power of two, ≥2).
- `HALT_OP`, `{W{1'b1}}`, opcode that stops fetch.

Ports:
- `clk`  in  1  clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `prog_ctr`  in  D  current PC from the program counter.
- `pc_hold`  out  1  PC must not advance this cycle.
- `imem_addr`  out  D  ROM read address.
- `imem_rdata`  in  W  ROM data, valid 1 cycle after address.
- `flush`  in  1  taken jump from decode; same cycle as PC `absjump_en`.
- `instr_valid`  out  1  FIFO head valid.
- `instr_ready`  in  1  decode accepts head.
- `instr`  out  W  head instruction.
- `instr_pc`  out  D  PC of head instruction.
- `done`  out  1  halted and FIFO empty.
- `fetch_cnt`  out  16  accepted-instruction count (see Configuration).

## Operation
- States: `RUN`, `HALT`. Reset → `RUN`, FIFO empty, `inflight`=0.
- `pop` = `instr_valid && instr_ready`.
- `issue` = state==`RUN` && !`flush` && (`count` + `inflight` − `pop`) < `DEPTH`.
- `imem_addr` = `prog_ctr` (combinational). `pc_hold` = !`issue`.
- On `issue`: `inflight`←1, `inflight_pc`←`prog_ctr`; else `inflight`←0.
- When `inflight`=1 at an edge and no `flush`: push {`imem_rdata`, `inflight_pc`}.
- Push of `instr`==`HALT_OP`: state→`HALT`; the HALT entry itself is queued and delivered.
- `HALT`: no issue; FIFO drains normally; `done` = (state==`HALT` && `count`==0).
- `flush` (any state): FIFO cleared, in-flight response dropped, state→`RUN`; takes priority over push and pop in the same cycle (a simultaneous pop is still counted as consumed by decode).
- Simultaneous push and pop with FIFO full: legal; count unchanged.
- Pointers wrap modulo `DEPTH`; `count` is `$clog2(DEPTH)+1` bits, never exceeds `DEPTH`.

## Timing
- Reset values: `pc_hold`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `done`=0, `fetch_cnt`=0; `imem_addr` follows `prog_ctr`.
- Address at cycle N → instruction visible at FIFO head at N+2 if FIFO empty (ROM latency 1 + enqueue register 1).
- Steady state with `instr_ready`=1: one instruction per cycle, `pc_hold`=0.
- `flush` at cycle N: `instr_valid`=0 at N+1; PC holds target at N+1, issued at N+1, target instruction valid at N+3.
- Reset asserted mid-operation: all state cleared asynchronously; no partial pushes.
- Outputs `instr`, `instr_pc`, `instr_valid` driven from registers only.

## Configuration
- `FETCH_CNT_EN` defined: 16-bit `fetch_cnt` increments on each `pop` (wraps at 0xFFFF→0), cleared by reset, not cleared by `flush`.
- Undefined: counter logic omitted; `fetch_cnt` tied to 0.

## Structure
- Shared package `fetch_pkg`: `D`/`W` defaults, `HALT_OP`, `fetch_state_e` enum {`RUN`,`HALT`}, packed struct `fetch_entry_t` {instr, pc}.
- One sub-module: `fetch_fifo` (parameterised `DEPTH` × `fetch_entry_t`, push/pop/clear, count, full/empty).

## Test plan
- Reset, ROM[0..3]=0x011,0x022,0x033,0x044, `instr_ready`=1 → valid at cycle 2 with pc 0, then pcs 1,2,3 back-to-back, `pc_hold` never high.
- `instr_ready`=0 from cycle 0 → exactly 2 entries (pc 0,1) queued, `pc_hold`=1 from cycle 2; release → pcs 0,1,2 in order, no loss/duplicate.
- `flush` at cycle 5 with target 0x200 → queued entries discarded, next `instr_pc`=0x200 at cycle 8.
- ROM[3]=0x1FF → fetch stops after pc 3, pcs 0–3 delivered, `done`=1 one cycle after last pop.
- HALT queued then `flush` to 0x010 → HALT entry discarded, state `RUN`, pc 0x010 delivered, `done` stays 0.
- Async `reset` pulse mid-stream (between clock edges) → `instr_valid`, `fetch_cnt` immediately 0; with `FETCH_CNT_EN`, 5 pops → `fetch_cnt`=5.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

  // Default PC / instruction-address width and instruction width.
  localparam int FETCH_D = 10;
  localparam int FETCH_W = 9;

  // Opcode that stops further fetching once it has been queued.
  localparam logic [FETCH_W-1:0] FETCH_HALT_OP = {FETCH_W{1'b1}};

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // One queued fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [FETCH_W-1:0] instr;
    logic [FETCH_D-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch entries with synchronous clear.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: a push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          head_valid,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_next;
  logic            full;
  logic            do_pop;
  logic            do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && head_valid;
  // With a simultaneous pop the slot being freed is reused, so full is no obstacle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage, pointers and occupancy; clear wins over push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count      <= count_next;
      head_valid <= (count_next != '0);
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: drives the ROM address from the PC, queues {instr, pc} for decode, stops after HALT; FETCH_CNT_EN adds an accepted-instruction counter.
// Latency: PC presented in cycle N reaches the FIFO head in cycle N+2 when the FIFO is empty.
// Backpressure: pc_hold rises whenever queued plus in-flight entries would exceed DEPTH after this cycle's pop.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int           D       = FETCH_D,
  parameter int           W       = FETCH_W,
  parameter int           DEPTH   = 2,
  parameter logic [W-1:0] HALT_OP = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] prog_ctr,
  output logic         pc_hold,
  output logic [D-1:0] imem_addr,
  input  logic [W-1:0] imem_rdata,
  input  logic         flush,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [W-1:0] instr,
  output logic [D-1:0] instr_pc,
  output logic         done,
  output logic [15:0]  fetch_cnt
);

  localparam int          CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic          inflight_q;
  logic [D-1:0]  inflight_pc_q;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;

  assign pop = instr_valid && instr_ready;

  // Slots committed after this cycle: queued + the ROM read in flight - the entry leaving now.
  assign occ   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue = (state_q == RUN) && !flush && (occ < DEPTH_OCC);

  assign imem_addr = prog_ctr;
  assign pc_hold   = !issue;

  // The read issued in the HALT cycle is wrong-path; only RUN responses are queued.
  assign push             = inflight_q && !flush && (state_q == RUN);
  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = inflight_pc_q;

  assign instr    = head.instr;
  assign instr_pc = head.pc;
  assign done     = (state_q == HALT) && fifo_empty;

  // Track the single outstanding ROM read and the PC it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= prog_ctr;
      end
    end
  end

  // Fetch state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Enter HALT when the HALT word is queued; a taken jump always resumes fetching.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RUN;
    end else if (push && (imem_rdata == HALT_OP)) begin
      state_d = HALT;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (instr_valid),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

`ifdef FETCH_CNT_EN
  logic [15:0] cnt_q;

  // Count instructions accepted by decode; a flush does not clear the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = cnt_q;
`else
  assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a scoreboard queue and a decoupled pop monitor.
// Latency: n/a (bench).
// Backpressure: bench drives instr_ready directly.
module tb_fetch_buffer;

  localparam int D = 10;
  localparam int W = 9;
`ifdef FETCH_CNT_EN
  localparam logic [31:0] CNT_AFTER_5 = 32'd5;
`else
  localparam logic [31:0] CNT_AFTER_5 = 32'd0;
`endif

  typedef struct packed {
    logic [W-1:0] instr;
    logic [D-1:0] pc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         instr_ready = 1'b0;
  logic [D-1:0] flush_tgt = '0;
  logic [D-1:0] prog_ctr;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_rdata = '0;
  logic         pc_hold;
  logic         instr_valid;
  logic [W-1:0] instr;
  logic [D-1:0] instr_pc;
  logic         done;
  logic [15:0]  fetch_cnt;
  logic [W-1:0] rom [0:1023];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic hold_seen;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fetch_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .prog_ctr    (prog_ctr),
    .pc_hold     (pc_hold),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .done        (done),
    .fetch_cnt   (fetch_cnt)
  );

  // Program counter: jump on flush, otherwise advance unless held.
  always @(posedge clk or posedge reset) begin
    if (reset) prog_ctr <= '0;
    else if (flush) prog_ctr <= flush_tgt;
    else if (!pc_hold) prog_ctr <= prog_ctr + 10'd1;
  end

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] i, input logic [D-1:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    exp_q.push_back(e);
  endtask

  // ROM[i] = (i+1)*17 mod 512: 0x011, 0x022, 0x033, ...
  task automatic fill_rom();
    for (int i = 0; i < 1024; i++) rom[i] = W'((i + 1) * 17);
  endtask

  task automatic start_test();
    reset = 1'b1;
    flush = 1'b0;
    instr_ready = 1'b0;
    @(posedge clk);
    #1;
    fill_rom();
    exp_q.delete();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Monitor: every accepted head is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual pc=0x%0h instr=0x%0h required=no pop", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", 32'(instr), 32'(e.instr));
          check("sb_pc", 32'(instr_pc), 32'(e.pc));
        end
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_rom();
    #1 reset = 1'b1;
    #1;
    check("rst_pc_hold", 32'(pc_hold), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);

    // 1: streaming with decode always ready.
    start_test();
    instr_ready = 1'b1;
    push_exp(9'h011, 10'd0); push_exp(9'h022, 10'd1);
    push_exp(9'h033, 10'd2); push_exp(9'h044, 10'd3);
    push_exp(9'h055, 10'd4); push_exp(9'h066, 10'd5);
    push_exp(9'h077, 10'd6); push_exp(9'h088, 10'd7);
    hold_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      run_to(c);
      #1;
      if (pc_hold) hold_seen = 1'b1;
      if (c == 1) check("t1_valid_c1", 32'(instr_valid), 32'd0);
      if (c == 2) begin
        check("t1_valid_c2", 32'(instr_valid), 32'd1);
        check("t1_pc_c2", 32'(instr_pc), 32'd0);
      end
    end
    run_to(10);
    instr_ready = 1'b0;
    check("t1_hold_never", 32'(hold_seen), 32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: decode stalled from cycle 0, then released.
    start_test();
    push_exp(9'h011, 10'd0); push_exp(9'h022, 10'd1);
    push_exp(9'h033, 10'd2); push_exp(9'h044, 10'd3);
    run_to(1); #1;
    check("t2_hold_c1", 32'(pc_hold), 32'd0);
    run_to(2); #1;
    check("t2_hold_c2", 32'(pc_hold), 32'd1);
    run_to(5); #1;
    check("t2_hold_c5", 32'(pc_hold), 32'd1);
    check("t2_head_pc", 32'(instr_pc), 32'd0);
    check("t2_pc_stopped", 32'(prog_ctr), 32'd2);
    run_to(6);
    instr_ready = 1'b1;
    #1;
    check("t2_hold_release", 32'(pc_hold), 32'd0);
    run_to(10);
    instr_ready = 1'b0;
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: flush at cycle 5 to 0x200 discards queued entries.
    start_test();
    run_to(5);
    flush_tgt = 10'h200;
    flush = 1'b1;
    #1;
    check("t3_valid_pre", 32'(instr_valid), 32'd1);
    check("t3_hold_flush", 32'(pc_hold), 32'd1);
    run_to(6);
    flush = 1'b0;
    instr_ready = 1'b1;
    push_exp(9'h011, 10'h200); push_exp(9'h022, 10'h201);
    #1;
    check("t3_valid_n1", 32'(instr_valid), 32'd0);
    check("t3_pc_target", 32'(prog_ctr), 32'h200);
    check("t3_hold_n1", 32'(pc_hold), 32'd0);
    run_to(7); #1;
    check("t3_valid_n2", 32'(instr_valid), 32'd0);
    run_to(8); #1;
    check("t3_valid_n3", 32'(instr_valid), 32'd1);
    check("t3_pc_n3", 32'(instr_pc), 32'h200);
    run_to(10);
    instr_ready = 1'b0;
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: HALT at pc 3 stops fetch; done follows the last pop.
    start_test();
    rom[3] = 9'h1FF;
    instr_ready = 1'b1;
    push_exp(9'h011, 10'd0); push_exp(9'h022, 10'd1);
    push_exp(9'h033, 10'd2); push_exp(9'h1FF, 10'd3);
    run_to(5); #1;
    check("t4_done_c5", 32'(done), 32'd0);
    check("t4_halt_pc", 32'(instr_pc), 32'd3);
    check("t4_halt_instr", 32'(instr), 32'h1FF);
    run_to(6); #1;
    check("t4_done_c6", 32'(done), 32'd1);
    check("t4_hold_c6", 32'(pc_hold), 32'd1);
    check("t4_valid_c6", 32'(instr_valid), 32'd0);
    run_to(9); #1;
    check("t4_done_c9", 32'(done), 32'd1);
    check("t4_valid_c9", 32'(instr_valid), 32'd0);
    instr_ready = 1'b0;
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: HALT queued, then flush to 0x010 resumes fetching.
    start_test();
    rom[1] = 9'h1FF;
    run_to(4); #1;
    check("t5_done_queued", 32'(done), 32'd0);
    check("t5_hold_halt", 32'(pc_hold), 32'd1);
    check("t5_head_pc", 32'(instr_pc), 32'd0);
    run_to(5);
    flush_tgt = 10'h010;
    flush = 1'b1;
    run_to(6);
    flush = 1'b0;
    instr_ready = 1'b1;
    push_exp(9'h121, 10'h010); push_exp(9'h132, 10'h011);
    #1;
    check("t5_valid_n1", 32'(instr_valid), 32'd0);
    check("t5_run_again", 32'(pc_hold), 32'd0);
    check("t5_done_n1", 32'(done), 32'd0);
    run_to(8); #1;
    check("t5_valid_n3", 32'(instr_valid), 32'd1);
    check("t5_pc_n3", 32'(instr_pc), 32'h010);
    run_to(10);
    instr_ready = 1'b0;
    check("t5_done_end", 32'(done), 32'd0);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6: five pops, then an asynchronous reset pulse between edges.
    start_test();
    instr_ready = 1'b1;
    push_exp(9'h011, 10'd0); push_exp(9'h022, 10'd1);
    push_exp(9'h033, 10'd2); push_exp(9'h044, 10'd3);
    push_exp(9'h055, 10'd4);
    run_to(7);
    instr_ready = 1'b0;
    #1;
    check("t6_fetch_cnt", 32'(fetch_cnt), CNT_AFTER_5);
    check("t6_valid_pre", 32'(instr_valid), 32'd1);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(instr_valid), 32'd0);
    check("t6_async_cnt", 32'(fetch_cnt), 32'd0);
    check("t6_async_pc", 32'(instr_pc), 32'd0);
    check("t6_async_hold", 32'(pc_hold), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    cyc = 0;
    instr_ready = 1'b1;
    push_exp(9'h011, 10'd0);
    run_to(2); #1;
    check("t6_restart_valid", 32'(instr_valid), 32'd1);
    check("t6_restart_pc", 32'(instr_pc), 32'd0);
    run_to(3);
    instr_ready = 1'b0;
    check("t6_restart_sb", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
